// File: rtl/common.sv
// Types shared across the pipeline control blocks.
package common;

    typedef logic [4:0] creg_addr_t;

endpackage

// File: rtl/pipes.sv
// Pipeline-control types for the ID-stage hazard controller.
package pipes;

    typedef enum logic [1:0] {
        ALU    = 2'd0,
        LOAD   = 2'd1,
        MULDIV = 2'd2,
        RSV    = 2'd3
    } hz_op_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_LD = 2'd1,
        WAIT_MD = 2'd2
    } hz_state_t;

    localparam int unsigned HZ_TIMEOUT_DEFAULT = 1024;

endpackage

// File: rtl/hazard_ctrl.sv
// ID-stage interlock: tracks one in-flight long-latency op, stalls dependent or
// competing instructions, and watchdogs the pending op.
module hazard_ctrl
    import common::*;
    import pipes::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = HZ_TIMEOUT_DEFAULT,
    parameter int unsigned CNT_W          = 11
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       issue_valid,
    input  creg_addr_t srca,
    input  creg_addr_t srcb,
    input  creg_addr_t dst,
    input  logic       dst_valid,
    input  hz_op_t     op_kind,
    input  logic       mem_resp,
    input  logic       muldiv_done,
    input  logic       flush,
    output logic       stall,
    output logic       bubble,
    output logic       accept,
    output logic       pend_valid,
    output creg_addr_t pend_dst,
    output logic       timeout
);

    localparam logic [CNT_W-1:0] TMO = CNT_W'(TIMEOUT_CYCLES);

    hz_state_t        state_q, state_d;
    logic             pend_valid_q, pend_valid_d;
    creg_addr_t       pend_dst_q, pend_dst_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             timeout_q, timeout_d;

    logic raw, waw, busy, is_long;

    // Hazards look only at registered state, so a completion never bypasses
    // into the same cycle's stall decision.
    assign is_long = (op_kind == LOAD) || (op_kind == MULDIV);
    assign raw     = pend_valid_q && ((srca == pend_dst_q) || (srcb == pend_dst_q));
    assign waw     = pend_valid_q && dst_valid && (dst == pend_dst_q);
    assign busy    = (state_q != IDLE) && is_long;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            pend_valid_q <= 1'b0;
            pend_dst_q   <= '0;
            cnt_q        <= '0;
            timeout_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q      <= state_d;
            pend_valid_q <= pend_valid_d;
            pend_dst_q   <= pend_dst_d;
            cnt_q        <= cnt_d;
            timeout_q    <= timeout_d;
        end
    end

    always_comb begin
        // NOTE: defaults first so no path through the case leaves a latch.
        state_d      = state_q;
        pend_valid_d = pend_valid_q;
        pend_dst_d   = pend_dst_q;
        cnt_d        = cnt_q;
        timeout_d    = timeout_q;
        unique case (state_q)
            IDLE: begin
                if (accept && is_long) begin
                    state_d      = (op_kind == LOAD) ? WAIT_LD : WAIT_MD;
                    pend_valid_d = dst_valid && (dst != '0);
                    pend_dst_d   = dst_valid ? dst : '0;
                    cnt_d        = '0;
                end
            end
            WAIT_LD, WAIT_MD: begin
                if ((state_q == WAIT_LD) ? mem_resp : muldiv_done) begin
                    state_d      = IDLE;
                    pend_valid_d = 1'b0;
                    pend_dst_d   = '0;
                    cnt_d        = '0;
                end else begin
                    if (cnt_q != TMO) cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_d == TMO) timeout_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Flush wins over stall and never disturbs the older pending op.
    always_comb begin
        stall  = issue_valid && !flush && (raw || waw || busy);
        bubble = stall;
        accept = issue_valid && !flush && !stall;
    end

    assign pend_valid = pend_valid_q;
    assign pend_dst   = pend_dst_q;
    assign timeout    = timeout_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed, table-driven bench for hazard_ctrl with hand sequences for
// the watchdog and asynchronous reset corner cases.
module tb_hazard_ctrl;
    import common::*;
    import pipes::*;

    typedef struct {
        logic       iv;
        creg_addr_t a;
        creg_addr_t b;
        creg_addr_t d;
        logic       dv;
        hz_op_t     op;
        logic       mr;
        logic       md;
        logic       fl;
        logic       e_stall;
        logic       e_acc;
        logic       e_pv;
        creg_addr_t e_pd;
        logic       e_to;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       issue_valid = 1'b0;
    creg_addr_t srca = '0, srcb = '0, dst = '0;
    logic       dst_valid = 1'b0;
    hz_op_t     op_kind = ALU;
    logic       mem_resp = 1'b0, muldiv_done = 1'b0, flush = 1'b0;
    logic       stall, bubble, accept, pend_valid, timeout;
    creg_addr_t pend_dst;

    int n_tests = 0;
    int n_fail  = 0;

    localparam int NV = 27;
    vec_t vecs [NV];

    hazard_ctrl #(.TIMEOUT_CYCLES(4), .CNT_W(3)) dut (
        .clk(clk), .reset(reset), .issue_valid(issue_valid),
        .srca(srca), .srcb(srcb), .dst(dst), .dst_valid(dst_valid),
        .op_kind(op_kind), .mem_resp(mem_resp), .muldiv_done(muldiv_done),
        .flush(flush), .stall(stall), .bubble(bubble), .accept(accept),
        .pend_valid(pend_valid), .pend_dst(pend_dst), .timeout(timeout)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic iv, input int a, input int b, input int d,
                                input logic dv, input hz_op_t op, input logic mr,
                                input logic md, input logic fl, input logic es,
                                input logic ea, input logic epv, input int epd,
                                input logic eto);
        vec_t v;
        v.iv = iv; v.a = 5'(a); v.b = 5'(b); v.d = 5'(d); v.dv = dv; v.op = op;
        v.mr = mr; v.md = md; v.fl = fl;
        v.e_stall = es; v.e_acc = ea; v.e_pv = epv; v.e_pd = 5'(epd); v.e_to = eto;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got {stall,bubble,accept,pv,pd,to}=%b required %b",
                     name, act[9:0], exp[9:0]);
        end
    endtask

    task automatic drive(input vec_t v);
        issue_valid = v.iv; srca = v.a; srcb = v.b; dst = v.d; dst_valid = v.dv;
        op_kind = v.op; mem_resp = v.mr; muldiv_done = v.md; flush = v.fl;
    endtask

    task automatic compare(input string name, input vec_t v);
        check(name, 32'({stall, bubble, accept, pend_valid, pend_dst, timeout}),
              32'({v.e_stall, v.e_stall, v.e_acc, v.e_pv, v.e_pd, v.e_to}));
    endtask

    task automatic step(input string name, input vec_t v);
        @(negedge clk);
        drive(v);
        #1;
        compare(name, v);
    endtask

    initial begin
        //            iv a  b  d  dv op      mr md fl | st ac pv pd to
        vecs[0]  = mk(1, 1, 2, 5, 1, LOAD,   0, 0, 0,   0, 1, 0, 0, 0);
        vecs[1]  = mk(1, 5, 0, 6, 1, ALU,    0, 0, 0,   1, 0, 1, 5, 0);
        vecs[2]  = mk(1, 5, 0, 6, 1, ALU,    0, 0, 0,   1, 0, 1, 5, 0);
        vecs[3]  = mk(1, 5, 0, 6, 1, ALU,    0, 0, 0,   1, 0, 1, 5, 0);
        vecs[4]  = mk(1, 5, 0, 6, 1, ALU,    1, 0, 0,   1, 0, 1, 5, 0);
        vecs[5]  = mk(1, 5, 0, 6, 1, ALU,    0, 0, 0,   0, 1, 0, 0, 0);
        vecs[6]  = mk(1, 3, 4, 0, 1, LOAD,   0, 0, 0,   0, 1, 0, 0, 0);
        vecs[7]  = mk(1, 0, 0, 8, 1, ALU,    0, 0, 0,   0, 1, 0, 0, 0);
        vecs[8]  = mk(1, 1, 2, 10, 1, MULDIV, 0, 0, 0,  1, 0, 0, 0, 0);
        vecs[9]  = mk(1, 1, 2, 10, 1, MULDIV, 0, 1, 0,  1, 0, 0, 0, 0);
        vecs[10] = mk(1, 1, 2, 10, 1, MULDIV, 1, 0, 0,  1, 0, 0, 0, 0);
        vecs[11] = mk(1, 1, 2, 7, 1, MULDIV, 0, 0, 0,   0, 1, 0, 0, 0);
        vecs[12] = mk(1, 1, 2, 7, 1, ALU,    0, 0, 0,   1, 0, 1, 7, 0);
        vecs[13] = mk(1, 1, 2, 7, 0, ALU,    0, 0, 0,   0, 1, 1, 7, 0);
        vecs[14] = mk(1, 1, 2, 9, 1, LOAD,   1, 0, 0,   1, 0, 1, 7, 0);
        vecs[15] = mk(1, 1, 2, 9, 1, LOAD,   0, 1, 0,   1, 0, 1, 7, 0);
        vecs[16] = mk(1, 1, 2, 9, 1, LOAD,   0, 0, 0,   0, 1, 0, 0, 0);
        vecs[17] = mk(0, 9, 0, 1, 1, LOAD,   0, 0, 0,   0, 0, 1, 9, 0);
        vecs[18] = mk(1, 9, 0, 1, 1, ALU,    0, 0, 1,   0, 0, 1, 9, 0);
        vecs[19] = mk(1, 0, 9, 1, 1, ALU,    0, 0, 0,   1, 0, 1, 9, 0);
        vecs[20] = mk(0, 0, 0, 0, 0, ALU,    1, 0, 0,   0, 0, 1, 9, 0);
        vecs[21] = mk(1, 1, 2, 3, 1, RSV,    0, 0, 0,   0, 1, 0, 0, 0);
        vecs[22] = mk(1, 1, 2, 3, 1, LOAD,   0, 0, 0,   0, 1, 0, 0, 0);
        vecs[23] = mk(1, 3, 0, 1, 1, ALU,    0, 0, 1,   0, 0, 1, 3, 0);
        vecs[24] = mk(1, 3, 0, 1, 1, ALU,    0, 0, 0,   1, 0, 1, 3, 0);
        vecs[25] = mk(0, 0, 0, 0, 0, ALU,    1, 0, 0,   0, 0, 1, 3, 0);
        vecs[26] = mk(0, 0, 0, 0, 0, ALU,    0, 0, 0,   0, 0, 0, 0, 0);

        // Reset state with a valid issue in ID.
        drive(mk(1, 0, 0, 0, 0, ALU, 0, 0, 0, 0, 0, 0, 0, 0));
        #1 reset = 1'b1;
        #1 compare("reset_state", mk(1, 0, 0, 0, 0, ALU, 0, 0, 0, 0, 1, 0, 0, 0));
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < NV; i++)
            step($sformatf("vec%0d", i), vecs[i]);

        // Watchdog: no completion for the LOAD; timeout appears after 4 wait cycles.
        step("wd_accept", mk(1, 1, 2, 4, 1, LOAD, 0, 0, 0, 0, 1, 0, 0, 0));
        for (int k = 0; k <= 5; k++)
            step($sformatf("wd_wait%0d", k),
                 mk(0, 0, 0, 0, 0, ALU, 0, 0, 0, 0, 0, 1, 4, (k >= 4)));
        step("wd_resp", mk(0, 0, 0, 0, 0, ALU, 1, 0, 0, 0, 0, 1, 4, 1));
        step("wd_sticky", mk(1, 1, 2, 6, 1, LOAD, 0, 0, 0, 0, 1, 0, 0, 1));
        step("wd_pending", mk(0, 0, 0, 0, 0, ALU, 0, 0, 0, 0, 0, 1, 6, 1));

        // Asynchronous reset in the middle of a wait, between clock edges.
        #2 reset = 1'b1;
        drive(mk(1, 6, 0, 1, 1, ALU, 0, 0, 0, 0, 0, 0, 0, 0));
        #1 compare("rst_async", mk(1, 6, 0, 1, 1, ALU, 0, 0, 0, 0, 1, 0, 0, 0));
        @(negedge clk);
        reset = 1'b0;
        step("rst_issue", mk(1, 6, 0, 1, 1, ALU, 0, 0, 0, 0, 1, 0, 0, 0));
        step("late_done", mk(0, 0, 0, 0, 0, ALU, 1, 1, 0, 0, 0, 0, 0, 0));
        step("idle_load", mk(1, 1, 2, 5, 1, LOAD, 1, 0, 0, 0, 1, 0, 0, 0));
        step("load_use", mk(1, 5, 0, 1, 1, ALU, 0, 0, 0, 1, 0, 1, 5, 0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
